// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO
//                registers. It computes from latched operands and counts
//                down a fixed latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_op;
    logic [31:0]          r_x;
    logic [31:0]          r_y;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_signed;
    logic [63:0]          w_prod;
    logic                 w_x_neg;
    logic                 w_y_neg;
    logic [31:0]          w_x_mag;
    logic [31:0]          w_y_mag;
    logic [31:0]          w_divisor;
    logic [31:0]          w_uq;
    logic [31:0]          w_ur;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

    // Result is derived only from the latched operands, so x/y changes
    // during RUN cannot reach HI/LO.
    always_comb begin
        w_signed  = ~r_op[0];
        w_prod    = {{32{w_signed & r_x[31]}}, r_x} * {{32{w_signed & r_y[31]}}, r_y};
        w_x_neg   = w_signed & r_x[31];
        w_y_neg   = w_signed & r_y[31];
        w_x_mag   = w_x_neg ? (~r_x + 32'd1) : r_x;
        w_y_mag   = w_y_neg ? (~r_y + 32'd1) : r_y;
        w_divisor = (r_y == 32'd0) ? 32'd1 : w_y_mag;
        w_uq      = w_x_mag / w_divisor;
        w_ur      = w_x_mag % w_divisor;
        w_res_hi  = w_prod[63:32];
        w_res_lo  = w_prod[31:0];
        if (r_op[1]) begin
            if (r_y == 32'd0) begin
                w_res_hi = r_x;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                // Magnitude divide then re-sign; 0x80000000 / -1 falls out naturally.
                w_res_hi = w_x_neg ? (~w_ur + 32'd1) : w_ur;
                w_res_lo = (w_x_neg ^ w_y_neg) ? (~w_uq + 32'd1) : w_uq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_x     <= 32'd0;
            r_y     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (!op[2]) begin
                            r_op    <= op[1:0];
                            r_x     <= x;
                            r_y     <= y;
                            r_cnt   <= op[1] ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MUL_CYCLES);
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else if (op == c_OP_MTHI) begin
                            r_hi <= x;
                        end else if (op == c_OP_MTLO) begin
                            r_lo <= x;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_W'(1)) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Takes the same x/y operand bus as the ALU and owns the architectural HI/LO registers.
- Its busy output stalls the pipeline on HI/LO hazards.
- HI/LO read values feed the same writeback mux as the ALU result (MFHI/MFLO).

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (min 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (min 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch op this cycle (sampled on clk rise).
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
- x  in  32  operand A (rs).
- y  in  32  operand B (rt).
- flush  in  1  cancel an in-flight op (exception/branch squash).
- busy  out  1  op in progress.
- done  out  1  one-cycle pulse when HI/LO are written by a mul/div.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (rst_n=0, async): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, operand/result latches=0. Reset mid-operation aborts the op and leaves no residue.
- States: IDLE, RUN.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, flush=0:
  - Latch op, x, y.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. On the edge where counter==1:
  - hi/lo take the result.
  - done=1 for the following cycle; busy=0 in that same cycle.
  - State returns to IDLE.
- Timing: start sampled at edge T -> busy high for cycles T+1 .. T+N, hi/lo new and done=1 in cycle T+N+1 (N = MUL_CYCLES or DIV_CYCLES).
- MTHI/MTLO in IDLE with flush=0: write x to hi (MTHI) or lo (MTLO) at that edge, 1-cycle latency. No busy, no done. The other register is unchanged.
- start while RUN is ignored, whatever the op. The pipeline must not issue it; the unit must not corrupt the op in flight.
- Reserved op with start=1: no effect, stays IDLE.
- flush=1 in RUN: back to IDLE at the next edge, hi/lo unchanged, no done.
- flush=1 with start=1 in IDLE: start ignored.
- flush on the same edge as completion (counter==1): flush wins, no write.
- MULT: signed 32x32 -> 64-bit product; hi=[63:32], lo=[31:0].
- MULTU: same split, operands unsigned.
- DIVU: lo=x/y, hi=x%y, unsigned.
- DIV: quotient truncates toward zero; remainder takes the dividend's sign (x = lo*y + hi).
- DIV special case: x=0x80000000, y=0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=x. Still takes DIV_CYCLES, done pulses normally.
- Operands are latched at start. x/y changes during RUN have no effect.
- Implementation may be iterative (shift-add / restoring) or compute-then-count. Observable latency and results must match the above exactly for all parameter values ≥1.
- hi/lo are registered outputs only; no combinational path from x/y to hi/lo.

Test Plan:
1. MULT x=0xFFFFFFFE (-2), y=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle.
2. MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIV x=-7 (0xFFFFFFF9), y=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU x=100, y=0 -> lo=0xFFFFFFFF, hi=100. DIV x=0x80000000, y=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI x=0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged, busy/done stay 0. Then MTLO while RUN -> ignored, mul result lands intact.
5. DIVU start, flush asserted on busy cycle 4 -> busy drops next cycle, hi/lo keep prior values, no done. Also flush exactly on the completion edge -> no write.
6. Assert rst_n=0 mid-MULT (between clock edges) -> hi=lo=0 and busy=0 immediately without a clock edge. A new MULT after release completes normally.
